decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Parametrised RV32I instruction-decode pipeline stage between fetch and execute.
//  - Registers a fully decoded instruction one cycle after acceptance.
//  - Decodes register selects, sign-extended immediates for all formats, and
//    register-file enables.
//  - Uses valid/ready handshakes on both sides, with flush for branch redirects.
// PARAMETERS
//  XLEN        32  datapath width; immediates are sign-extended to XLEN
//  REG_AW      5   register-select width (5 = 32 architectural regs)
//  PC_W        32  width of the PC carried alongside the instruction
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        asynchronous active-low reset
//  flush_i      in   1        kill held/incoming instruction (redirect)
//  in_valid_i   in   1        fetch presents instr_i/pc_i
//  in_ready_o   out  1        stage can accept this cycle
//  instr_i      in   32       raw instruction
//  pc_i         in   PC_W     PC of instr_i
//  out_valid_o  out  1        decoded bundle valid
//  out_ready_i  in   1        execute accepts bundle
//  pc_o         out  PC_W     registered PC
//  opcode_o     out  5        instr[6:2]
//  funct3_o     out  3        instr[14:12]
//  funct7b5_o   out  1        instr[30]
//  sel_rs1_o    out  REG_AW   rs1 select
//  sel_rs2_o    out  REG_AW   rs2 select
//  sel_rd_o     out  REG_AW   rd select
//  rs1_en_o     out  1        rs1 is read
//  rs2_en_o     out  1        rs2 is read
//  rd_we_o      out  1        rd is written; always 0 when rd == x0
//  imm_o        out  XLEN     sign-extended immediate
//  illegal_o    out  1        illegal-instruction flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every output register is cleared to 0; out_valid_o = 0 and
//    in_ready_o = 1.
//  - Latency: 1 cycle from accept (in_valid_i & in_ready_o) to out_valid_o.
//  - Handshake: in_ready_o = ~out_valid_o | out_ready_i, combinational.
//    - Accept with no pending output: load the bundle and set out_valid_o.
//    - Output taken with no new accept: clear out_valid_o.
//    - Output taken and new accept in the same cycle: replace the bundle, and
//      out_valid_o stays 1 (full throughput).
//    - out_valid_o & ~out_ready_i: all outputs held stable and in_ready_o = 0.
//  - Flush: clears out_valid_o next cycle and discards any same-cycle accept.
//    Flush has priority over all other events. Data registers may keep stale
//    contents.
//  - Immediate formats, all with sign bit instr[31]:
//    - I (LOAD, OP-IMM, JALR): instr[31:20]
//    - S (STORE): {instr[31:25], instr[11:7]}
//    - B (BRANCH): {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
//    - U (LUI, AUIPC): {instr[31:12], 12'b0}
//    - J (JAL): {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
//    - R-type / other: imm = 0
//  - Enables:
//    - rs1_en: all opcodes except LUI, AUIPC and JAL.
//    - rs2_en: OP, STORE, BRANCH.
//    - rd_we: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, masked by rd != 0.
//  - Unlisted opcodes: enables = 0 and imm = 0. The bundle is still passed
//    through; it is never dropped.
// CONFIGURATION
//  - DECODE_ILLEGAL_CHECK_EN defined:
//    - illegal_o = 1 when instr[1:0] != 2'b11, the opcode is not RV32I, or the
//      funct3/funct7 combination is invalid for OP/OP-IMM shifts, LOAD, STORE
//      or BRANCH.
//    - Illegal bundles force rd_we_o = 0.
//  - Undefined: illegal_o is tied to 0 and no check logic is built.
// STRUCTURE
//  - Package riscv_pkg holds:
//    - opcode_e enum (LOAD=5'b00000, OP_IMM=5'b00100, AUIPC=5'b00101,
//      STORE=5'b01000, OP=5'b01100, LUI=5'b01101, BRANCH=5'b11000,
//      JALR=5'b11001, JAL=5'b11011)
//    - imm_fmt_e enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}
//    - decoded_t packed struct of the output bundle
//  - Sub-module imm_gen: combinational {instr, imm_fmt_e} -> XLEN immediate.
// TESTING
//  - ADDI x1,x2,-5 (0xFFB10093) -> next cycle out_valid=1, rs1=2, rd=1,
//    imm=0xFFFFFFFB, rs1_en=1, rs2_en=0, rd_we=1.
//  - SW x5,8(x6) (0x00532423) -> rs1=6, rs2=5, imm=8, rs2_en=1, rd_we=0.
//  - ADDI x0,x0,0 (0x00000013) -> rd_we=0; JAL x1,+2048 (0x001000EF) ->
//    imm=0x00000800, rs1_en=0.
//  - out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0 and outputs
//    unchanged. Release -> back-to-back transfers, one per cycle.
//  - flush_i with in_valid_i=1 and out_valid_o=1 -> out_valid_o=0 next cycle.
//    Reset asserted mid-stream -> all outputs 0 immediately.
//  - With DECODE_ILLEGAL_CHECK_EN, instr 0x00000000 -> illegal_o=1, rd_we_o=0.
//    Without the macro -> illegal_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode, immediate-format and decoded-bundle types for the decode stage
package riscv_pkg;

    typedef enum logic [4:0] {
        LOAD   = 5'b00000,
        OP_IMM = 5'b00100,
        AUIPC  = 5'b00101,
        STORE  = 5'b01000,
        OP     = 5'b01100,
        LUI    = 5'b01101,
        BRANCH = 5'b11000,
        JALR   = 5'b11001,
        JAL    = 5'b11011
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Control part of the output bundle; parameter-width fields live beside it in the stage
    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] funct3;
        logic       funct7b5;
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_we;
        logic       illegal;
    } decoded_t;

    function automatic imm_fmt_e imm_fmt_of(input logic [4:0] opc);
        imm_fmt_e fmt;
        case (opc)
            LOAD, OP_IMM, JALR: fmt = IMM_I;
            STORE:              fmt = IMM_S;
            BRANCH:             fmt = IMM_B;
            LUI, AUIPC:         fmt = IMM_U;
            JAL:                fmt = IMM_J;
            default:            fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate generator, sign-extended to XLEN
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode pipeline stage with valid/ready handshake and flush
// Optional DECODE_ILLEGAL_CHECK_EN builds the illegal-instruction checker.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [4:0]        opcode_o,
    output logic [2:0]        funct3_o,
    output logic              funct7b5_o,
    output logic [REG_AW-1:0] sel_rs1_o,
    output logic [REG_AW-1:0] sel_rs2_o,
    output logic [REG_AW-1:0] sel_rd_o,
    output logic              rs1_en_o,
    output logic              rs2_en_o,
    output logic              rd_we_o,
    output logic [XLEN-1:0]   imm_o,
    output logic              illegal_o
);

    logic [4:0]      opc;
    logic            illegal;
    logic            accept;
    logic [XLEN-1:0] imm_d;
    decoded_t        dec_d;
    decoded_t        dec_q;

    assign opc = instr_i[6:2];

`ifdef DECODE_ILLEGAL_CHECK_EN
    function automatic logic illegal_of(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        f3  = ins[14:12];
        f7  = ins[31:25];
        bad = (ins[1:0] != 2'b11);
        case (ins[6:2])
            LOAD:   bad = bad | (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7);
            STORE:  bad = bad | (f3 > 3'd2);
            BRANCH: bad = bad | (f3 == 3'd2) | (f3 == 3'd3);
            OP_IMM: begin
                if (f3 == 3'd1)
                    bad = bad | (f7 != 7'h00);
                else if (f3 == 3'd5)
                    bad = bad | ((f7 != 7'h00) && (f7 != 7'h20));
            end
            OP: begin
                // Only ADD/SUB and SRL/SRA have a funct7 alternative
                if ((f3 == 3'd0) || (f3 == 3'd5))
                    bad = bad | ((f7 != 7'h00) && (f7 != 7'h20));
                else
                    bad = bad | (f7 != 7'h00);
            end
            AUIPC, LUI, JAL, JALR: bad = bad;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign illegal = illegal_of(instr_i);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^instr_i[1:0];
    assign illegal         = 1'b0;
`endif

    always_comb begin
        dec_d          = '0;
        dec_d.opcode   = opc;
        dec_d.funct3   = instr_i[14:12];
        dec_d.funct7b5 = instr_i[30];
        dec_d.illegal  = illegal;
        case (opc)
            LOAD, OP_IMM, JALR: begin
                dec_d.rs1_en = 1'b1;
                dec_d.rd_we  = 1'b1;
            end
            OP: begin
                dec_d.rs1_en = 1'b1;
                dec_d.rs2_en = 1'b1;
                dec_d.rd_we  = 1'b1;
            end
            STORE, BRANCH: begin
                dec_d.rs1_en = 1'b1;
                dec_d.rs2_en = 1'b1;
            end
            LUI, AUIPC, JAL: dec_d.rd_we = 1'b1;
            default: dec_d.rd_we = 1'b0;
        endcase
        dec_d.rd_we = dec_d.rd_we & (instr_i[11:7] != 5'd0) & ~illegal;
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr_i[31:7]),
        .fmt   (imm_fmt_of(opc)),
        .imm   (imm_d)
    );

    assign in_ready_o = ~out_valid_o | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;

    // Flush wins over accept and drain; data registers may keep stale values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            dec_q       <= '0;
            pc_o        <= '0;
            sel_rs1_o   <= '0;
            sel_rs2_o   <= '0;
            sel_rd_o    <= '0;
            imm_o       <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            dec_q       <= dec_d;
            pc_o        <= pc_i;
            sel_rs1_o   <= REG_AW'(instr_i[19:15]);
            sel_rs2_o   <= REG_AW'(instr_i[24:20]);
            sel_rd_o    <= REG_AW'(instr_i[11:7]);
            imm_o       <= imm_d;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    assign opcode_o   = dec_q.opcode;
    assign funct3_o   = dec_q.funct3;
    assign funct7b5_o = dec_q.funct7b5;
    assign rs1_en_o   = dec_q.rs1_en;
    assign rs2_en_o   = dec_q.rs2_en;
    assign rd_we_o    = dec_q.rd_we;
    assign illegal_o  = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [4:0]  opcode_o;
    logic [2:0]  funct3_o;
    logic        funct7b5_o;
    logic [4:0]  sel_rs1_o;
    logic [4:0]  sel_rs2_o;
    logic [4:0]  sel_rd_o;
    logic        rs1_en_o;
    logic        rs2_en_o;
    logic        rd_we_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    int passed = 0;
    int total  = 0;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .pc_o        (pc_o),
        .opcode_o    (opcode_o),
        .funct3_o    (funct3_o),
        .funct7b5_o  (funct7b5_o),
        .sel_rs1_o   (sel_rs1_o),
        .sel_rs2_o   (sel_rs2_o),
        .sel_rd_o    (sel_rd_o),
        .rs1_en_o    (rs1_en_o),
        .rs2_en_o    (rs2_en_o),
        .rd_we_o     (rd_we_o),
        .imm_o       (imm_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_we;
        logic        ill;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bundle(input string tag, input vec_t v);
        chk({tag, " valid"},  {31'd0, out_valid_o}, 32'd1);
        chk({tag, " pc"},     pc_o, v.pc);
        chk({tag, " opcode"}, {27'd0, opcode_o}, {27'd0, v.opc});
        chk({tag, " funct3"}, {29'd0, funct3_o}, {29'd0, v.f3});
        chk({tag, " f7b5"},   {31'd0, funct7b5_o}, {31'd0, v.f7b5});
        chk({tag, " rs1"},    {27'd0, sel_rs1_o}, {27'd0, v.rs1});
        chk({tag, " rs2"},    {27'd0, sel_rs2_o}, {27'd0, v.rs2});
        chk({tag, " rd"},     {27'd0, sel_rd_o}, {27'd0, v.rd});
        chk({tag, " rs1_en"}, {31'd0, rs1_en_o}, {31'd0, v.rs1_en});
        chk({tag, " rs2_en"}, {31'd0, rs2_en_o}, {31'd0, v.rs2_en});
        chk({tag, " rd_we"},  {31'd0, rd_we_o}, {31'd0, v.rd_we});
        chk({tag, " illegal"},{31'd0, illegal_o}, {31'd0, v.ill});
        chk({tag, " imm"},    imm_o, v.imm);
    endtask

    initial begin
        //            instr         pc         opc       f3  f7 rs1 rs2 rd r1e r2e we ill imm
        vecs[0] = '{32'hFFB10093, 32'h100, 5'b00100, 3'd0, 1, 2, 27, 1, 1, 0, 1, 0, 32'hFFFFFFFB};
        vecs[1] = '{32'h00532423, 32'h104, 5'b01000, 3'd2, 0, 6, 5,  8, 1, 1, 0, 0, 32'h00000008};
        vecs[2] = '{32'h00000013, 32'h108, 5'b00100, 3'd0, 0, 0, 0,  0, 1, 0, 0, 0, 32'h00000000};
        vecs[3] = '{32'h001000EF, 32'h10C, 5'b11011, 3'd0, 0, 0, 1,  1, 0, 0, 1, 0, 32'h00000800};
        vecs[4] = '{32'h123452B7, 32'h110, 5'b01101, 3'd5, 0, 8, 3,  5, 0, 0, 1, 0, 32'h12345000};
        vecs[5] = '{32'hFE208EE3, 32'h114, 5'b11000, 3'd0, 1, 1, 2, 29, 1, 1, 0, 0, 32'hFFFFFFFC};
        vecs[6] = '{32'h002081B3, 32'h118, 5'b01100, 3'd0, 0, 1, 2,  3, 1, 1, 1, 0, 32'h00000000};
        vecs[7] = '{32'h000000FF, 32'h11C, 5'b11111, 3'd0, 0, 0, 0,  1, 0, 0, 0, ILL, 32'h00000000};
        vecs[8] = '{32'h00000000, 32'h120, 5'b00000, 3'd0, 0, 0, 0,  0, 1, 0, 0, ILL, 32'h00000000};

        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        instr_i     = 32'h0;
        pc_i        = 32'h0;
        out_ready_i = 1'b0;
        tick();
        tick();
        chk("reset out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("reset in_ready",  {31'd0, in_ready_o}, 32'd1);
        chk("reset pc",        pc_o, 32'd0);
        chk("reset imm",       imm_o, 32'd0);
        chk("reset rd_we",     {31'd0, rd_we_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream through the table with execute always ready
        out_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid_i = 1'b1;
            instr_i    = vecs[i].instr;
            pc_i       = vecs[i].pc;
            tick();
            chk_bundle($sformatf("vec%0d", i), vecs[i]);
        end
        in_valid_i = 1'b0;
        tick();
        chk("drain out_valid", {31'd0, out_valid_o}, 32'd0);

        // Backpressure: hold A for three cycles while B waits
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        instr_i     = vecs[0].instr;
        pc_i        = 32'h200;
        tick();
        instr_i = vecs[1].instr;
        pc_i    = 32'h204;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d in_ready", c), {31'd0, in_ready_o}, 32'd0);
            chk($sformatf("stall%0d valid", c), {31'd0, out_valid_o}, 32'd1);
            chk($sformatf("stall%0d pc", c), pc_o, 32'h200);
            chk($sformatf("stall%0d imm", c), imm_o, 32'hFFFFFFFB);
        end
        out_ready_i = 1'b1;
        #1;
        chk("release in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        chk("b2b B valid", {31'd0, out_valid_o}, 32'd1);
        chk("b2b B pc", pc_o, 32'h204);
        chk("b2b B imm", imm_o, 32'h8);
        instr_i = vecs[4].instr;
        pc_i    = 32'h208;
        tick();
        chk("b2b C valid", {31'd0, out_valid_o}, 32'd1);
        chk("b2b C pc", pc_o, 32'h208);
        chk("b2b C imm", imm_o, 32'h12345000);

        // Flush with a held bundle and a same-cycle incoming one
        instr_i = vecs[6].instr;
        pc_i    = 32'h300;
        flush_i = 1'b1;
        tick();
        chk("flush out_valid", {31'd0, out_valid_o}, 32'd0);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        tick();
        chk("post flush valid", {31'd0, out_valid_o}, 32'd0);

        // Asynchronous reset in the middle of a stream
        in_valid_i = 1'b1;
        instr_i    = vecs[0].instr;
        pc_i       = 32'h400;
        tick();
        chk("pre reset valid", {31'd0, out_valid_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", {31'd0, out_valid_o}, 32'd0);
        chk("async rst pc", pc_o, 32'd0);
        chk("async rst imm", imm_o, 32'd0);
        chk("async rst rs1", {27'd0, sel_rs1_o}, 32'd0);
        chk("async rst rd_we", {31'd0, rd_we_o}, 32'd0);
        chk("async rst in_ready", {31'd0, in_ready_o}, 32'd1);
        in_valid_i = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
